apb_master_n: RTL

Parametrised APB (AMBA APB4) requester. It accepts single transfer commands on a valid/ready command port and decodes the slave index from the address. It drives a shared APB bus to NUM_SLV completers using a proper IDLE/SETUP/ACCESS sequence. It returns read data and error status on a registered response pulse, and adds back-to-back issue, decode-error and wait-state timeout handling, which the earlier fixed 4-slave master lacks.

---
 rtl/apb_pkg.sv | 34 +++
 rtl/apb_master_n_if.sv | 55 +++++
 rtl/apb_addr_decode.sv | 46 ++++
 rtl/apb_master_n.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/apb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : apb_pkg
//  Description : Shared types and helpers for the APB requester: transfer
//                state encoding, protection-field width and a constant
//                ceil(log2) helper used to size index and counter fields.
//  Revision    : 1.0 - initial release
// ============================================================================
package apb_pkg;

    localparam int PROT_W = 3;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2,
        ST_DERR   = 2'd3
    } apb_state_e;

    // ceil(log2(value)); returns 0 for value <= 1.
    function automatic int clog2(input int value);
        int result;
        int v;
        result = 0;
        v      = value - 1;
        while (v > 0) begin
            result = result + 1;
            v      = v >> 1;
        end
        return result;
    endfunction

endpackage
`default_nettype wire

// File: rtl/apb_master_n_if.sv
`default_nettype none
// ============================================================================
//  Module      : apb_master_n_if
//  Description : Command/response port plus the shared APB bus of the
//                requester.
//                master modport : requester view (drives cmd_ready, rsp_*,
//                                 psel/penable/paddr/pwrite/pwdata/pstrb/pprot)
//                slave modport  : command source + completer view
//  Revision    : 1.0 - initial release
// ============================================================================
interface apb_master_n_if #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int NUM_SLV = 4
);
    logic                        cmd_valid;
    logic                        cmd_ready;
    logic [ADDR_W-1:0]           cmd_addr;
    logic                        cmd_write;
    logic [DATA_W-1:0]           cmd_wdata;
    logic [DATA_W/8-1:0]         cmd_strb;
    logic [apb_pkg::PROT_W-1:0]  cmd_prot;

    logic                        rsp_valid;
    logic [DATA_W-1:0]           rsp_rdata;
    logic                        rsp_err;
    logic                        rsp_timeout;

    logic [NUM_SLV-1:0]          psel;
    logic                        penable;
    logic [ADDR_W-1:0]           paddr;
    logic                        pwrite;
    logic [DATA_W-1:0]           pwdata;
    logic [DATA_W/8-1:0]         pstrb;
    logic [apb_pkg::PROT_W-1:0]  pprot;
    logic [NUM_SLV*DATA_W-1:0]   prdata;
    logic [NUM_SLV-1:0]          pready;
    logic [NUM_SLV-1:0]          pslverr;

    modport master (
        input  cmd_valid, cmd_addr, cmd_write, cmd_wdata, cmd_strb, cmd_prot,
        input  prdata, pready, pslverr,
        output cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
        output psel, penable, paddr, pwrite, pwdata, pstrb, pprot
    );

    modport slave (
        output cmd_valid, cmd_addr, cmd_write, cmd_wdata, cmd_strb, cmd_prot,
        output prdata, pready, pslverr,
        input  cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
        input  psel, penable, paddr, pwrite, pwdata, pstrb, pprot
    );

endinterface
`default_nettype wire

// File: rtl/apb_addr_decode.sv
`default_nettype none
// ============================================================================
//  Module      : apb_addr_decode
//  Description : Combinational completer decode. Takes the index field
//                addr[SEL_LSB +: IDX_W] and produces a one-hot select;
//                an index with no completer behind it raises err.
//  Ports       : addr (in, ADDR_W) - command address
//                sel  (out, NUM_SLV) - one-hot completer select
//                err  (out, 1)       - index >= NUM_SLV
//  Revision    : 1.0 - initial release
// ============================================================================
module apb_addr_decode
    import apb_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int NUM_SLV = 4,
    parameter int SEL_LSB = 12
) (
    input  wire logic [ADDR_W-1:0]  addr,
    output logic      [NUM_SLV-1:0] sel,
    output logic                    err
);

    localparam int IDX_W = (NUM_SLV > 1) ? clog2(NUM_SLV) : 1;

    logic [IDX_W-1:0] w_idx;
    logic             unused_addr;

    assign w_idx       = addr[SEL_LSB +: IDX_W];
    // Only the index field selects a completer; the remaining bits are
    // carried on paddr by the requester.
    assign unused_addr = ^addr;

    // An index matching no completer leaves sel all-zero, which is exactly
    // the decode-error condition.
    always_comb begin
        sel = '0;
        for (int i = 0; i < NUM_SLV; i++) begin
            sel[i] = (w_idx == IDX_W'(i));
        end
    end

    assign err = ~|sel;

endmodule
`default_nettype wire

// File: rtl/apb_master_n.sv
`default_nettype none
// ============================================================================
//  Module      : apb_master_n
//  Description : APB4 requester for NUM_SLV completers. Accepts one command
//                per valid/ready handshake, runs SETUP/ACCESS on the bus,
//                returns a one-cycle registered response. Supports
//                back-to-back issue, decode errors and wait-state timeout.
//  Ports       : pclk, preset (async, active-low)
//                bus (apb_master_n_if.master) - command, response, APB bus
//  Revision    : 1.0 - initial release
// ============================================================================
module apb_master_n
    import apb_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int NUM_SLV = 4,
    parameter int SEL_LSB = 12,
    parameter int TIMEOUT = 16
) (
    input  wire logic       pclk,
    input  wire logic       preset,
    apb_master_n_if.master  bus
);

    localparam int STRB_W = DATA_W / 8;
    localparam int CNT_W  = (clog2(TIMEOUT + 1) > 0) ? clog2(TIMEOUT + 1) : 1;
    localparam bit TMO_EN = (TIMEOUT != 0);
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT - 1);

    apb_state_e           state_q,       state_d;
    logic [NUM_SLV-1:0]   psel_q,        psel_d;
    logic                 penable_q,     penable_d;
    logic [ADDR_W-1:0]    paddr_q,       paddr_d;
    logic                 pwrite_q,      pwrite_d;
    logic [DATA_W-1:0]    pwdata_q,      pwdata_d;
    logic [STRB_W-1:0]    pstrb_q,       pstrb_d;
    logic [PROT_W-1:0]    pprot_q,       pprot_d;
    logic [CNT_W-1:0]     cnt_q,         cnt_d;
    logic                 rsp_valid_q,   rsp_valid_d;
    logic [DATA_W-1:0]    rsp_rdata_q,   rsp_rdata_d;
    logic                 rsp_err_q,     rsp_err_d;
    logic                 rsp_timeout_q, rsp_timeout_d;

    logic [NUM_SLV-1:0]   w_dec_sel;
    logic                 w_dec_err;
    logic                 w_sel_ready;
    logic                 w_sel_err;
    logic [DATA_W-1:0]    w_sel_rdata;
    logic                 w_cmd_ready;
    logic                 w_accept;

    apb_addr_decode #(
        .ADDR_W  (ADDR_W),
        .NUM_SLV (NUM_SLV),
        .SEL_LSB (SEL_LSB)
    ) u_addr_decode (
        .addr (bus.cmd_addr),
        .sel  (w_dec_sel),
        .err  (w_dec_err)
    );

    // psel_q doubles as the registered one-hot slave index, so the
    // completer-side mux is a plain AND-OR against it.
    assign w_sel_ready = |(bus.pready  & psel_q);
    assign w_sel_err   = |(bus.pslverr & psel_q);

    always_comb begin
        w_sel_rdata = '0;
        for (int i = 0; i < NUM_SLV; i++) begin
            if (psel_q[i]) begin
                w_sel_rdata = w_sel_rdata | bus.prdata[i*DATA_W +: DATA_W];
            end
        end
    end

    // Ready in IDLE, or on the completing ACCESS cycle for back-to-back
    // issue. Gated by preset so nothing is offered while in reset.
    assign w_cmd_ready = preset & ((state_q == ST_IDLE) |
                                   ((state_q == ST_ACCESS) & w_sel_ready));
    assign w_accept    = bus.cmd_valid & w_cmd_ready;

    always_comb begin
        state_d       = state_q;
        psel_d        = psel_q;
        penable_d     = penable_q;
        paddr_d       = paddr_q;
        pwrite_d      = pwrite_q;
        pwdata_d      = pwdata_q;
        pstrb_d       = pstrb_q;
        pprot_d       = pprot_q;
        cnt_d         = cnt_q;
        rsp_valid_d   = 1'b0;
        rsp_rdata_d   = '0;
        rsp_err_d     = 1'b0;
        rsp_timeout_d = 1'b0;

        if (w_accept) begin
            paddr_d   = bus.cmd_addr;
            pwrite_d  = bus.cmd_write;
            pwdata_d  = bus.cmd_wdata;
            pstrb_d   = bus.cmd_write ? bus.cmd_strb : '0;
            pprot_d   = bus.cmd_prot;
            psel_d    = w_dec_err ? '0 : w_dec_sel;
            penable_d = 1'b0;
            state_d   = w_dec_err ? ST_DERR : ST_SETUP;
        end

        unique case (state_q)
            ST_SETUP: begin
                state_d   = ST_ACCESS;
                penable_d = 1'b1;
                cnt_d     = '0;
            end
            ST_ACCESS: begin
                // pready wins over an expiring count on the same cycle.
                if (w_sel_ready) begin
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = w_sel_err;
                    rsp_rdata_d = (pwrite_q || w_sel_err) ? '0 : w_sel_rdata;
                    if (!w_accept) begin
                        state_d   = ST_IDLE;
                        psel_d    = '0;
                        penable_d = 1'b0;
                    end
                end else if (TMO_EN && (cnt_q == TMO_LAST)) begin
                    state_d       = ST_IDLE;
                    psel_d        = '0;
                    penable_d     = 1'b0;
                    rsp_valid_d   = 1'b1;
                    rsp_err_d     = 1'b1;
                    rsp_timeout_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_DERR: begin
                state_d     = ST_IDLE;
                rsp_valid_d = 1'b1;
                rsp_err_d   = 1'b1;
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge pclk or negedge preset) begin
        if (!preset) begin
            state_q       <= ST_IDLE;
            psel_q        <= '0;
            penable_q     <= 1'b0;
            paddr_q       <= '0;
            pwrite_q      <= 1'b0;
            pwdata_q      <= '0;
            pstrb_q       <= '0;
            pprot_q       <= '0;
            cnt_q         <= '0;
            rsp_valid_q   <= 1'b0;
            rsp_rdata_q   <= '0;
            rsp_err_q     <= 1'b0;
            rsp_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            psel_q        <= psel_d;
            penable_q     <= penable_d;
            paddr_q       <= paddr_d;
            pwrite_q      <= pwrite_d;
            pwdata_q      <= pwdata_d;
            pstrb_q       <= pstrb_d;
            pprot_q       <= pprot_d;
            cnt_q         <= cnt_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_rdata_q   <= rsp_rdata_d;
            rsp_err_q     <= rsp_err_d;
            rsp_timeout_q <= rsp_timeout_d;
        end
    end

    assign bus.cmd_ready   = w_cmd_ready;
    assign bus.psel        = psel_q;
    assign bus.penable     = penable_q;
    assign bus.paddr       = paddr_q;
    assign bus.pwrite      = pwrite_q;
    assign bus.pwdata      = pwdata_q;
    assign bus.pstrb       = pstrb_q;
    assign bus.pprot       = pprot_q;
    assign bus.rsp_valid   = rsp_valid_q;
    assign bus.rsp_rdata   = rsp_rdata_q;
    assign bus.rsp_err     = rsp_err_q;
    assign bus.rsp_timeout = rsp_timeout_q;

endmodule
`default_nettype wire
